// File: rtl/raycast_pkg.sv
// Shared types and constants for the ray setup stage.
//   fix_t                : signed 8.8 fixed-point value
//   FRAC_BITS            : fractional bits in fix_t
//   SCREEN_WIDTH_DEFAULT : default number of screen columns
//   raygen_state_t       : frame sequencer states
package raycast_pkg;

  typedef logic signed [15:0] fix_t;

  localparam int unsigned FRAC_BITS            = 8;
  localparam int unsigned SCREEN_WIDTH_DEFAULT = 320;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } raygen_state_t;

endpackage

// File: rtl/fix_mul_shift.sv
// Registered signed 16x16 multiply; the registered 32-bit product is shifted
// right arithmetically by FRAC_BITS and truncated to 16 bits on the output.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   en_i   : load a new product (held when low)
//   a_i    : signed 16-bit operand
//   b_i    : signed 16-bit operand
//   res_o  : (a*b)>>>FRAC_BITS, truncated to 16 bits
module fix_mul_shift
  import raycast_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] res_o
);

  logic signed [31:0] prod_q;
  logic signed [31:0] prod_d;

  always_comb begin
    prod_d = prod_q;
    if (en_i) begin
      prod_d = 32'($signed(a_i)) * 32'($signed(b_i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign res_o = 16'(prod_q >>> FRAC_BITS);

endmodule

// File: rtl/ray_column_gen.sv
// Per-frame ray setup: latches the camera pose on start_in, then emits one
// ray descriptor per screen column over a valid/ready handshake.
//   clk_in, rst_n_in            : clock, asynchronous active-low reset
//   start_in                    : frame start pulse (honoured only when idle)
//   pos/dir/plane _x/_y _in     : camera pose, signed 8.8
//   ray_ready_in                : downstream accepts a descriptor
//   ray_valid_out               : descriptor valid
//   ray_col_out                 : column index
//   ray_dir_x/_y_out            : ray direction, signed 8.8
//   map_x/_y_out                : integer map cell of the player
//   step_x/_y_neg_out           : ray direction component is negative
//   ray_last_out                : descriptor is the last column
//   pose_x/_y_out               : latched player position
//   busy_out, frame_done_out    : frame in progress, end-of-frame pulse
module ray_column_gen
  import raycast_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = SCREEN_WIDTH_DEFAULT
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [15:0]                     pos_x_in,
  input  logic [15:0]                     pos_y_in,
  input  logic [15:0]                     dir_x_in,
  input  logic [15:0]                     dir_y_in,
  input  logic [15:0]                     plane_x_in,
  input  logic [15:0]                     plane_y_in,
  input  logic                            ray_ready_in,
  output logic                            ray_valid_out,
  output logic [$clog2(SCREEN_WIDTH)-1:0] ray_col_out,
  output logic [15:0]                     ray_dir_x_out,
  output logic [15:0]                     ray_dir_y_out,
  output logic [7:0]                      map_x_out,
  output logic [7:0]                      map_y_out,
  output logic                            step_x_neg_out,
  output logic                            step_y_neg_out,
  output logic                            ray_last_out,
  output logic [15:0]                     pose_x_out,
  output logic [15:0]                     pose_y_out,
  output logic                            busy_out,
  output logic                            frame_done_out
);

  localparam int unsigned ColW   = $clog2(SCREEN_WIDTH);
  // err stays below W, err+R below 2W.
  localparam int unsigned ErrW   = ColW + 2;
  localparam int unsigned Span   = 2 << FRAC_BITS;
  localparam int unsigned StepQ  = Span / SCREEN_WIDTH;
  localparam int unsigned StepR  = Span % SCREEN_WIDTH;

  localparam logic [ColW-1:0] LastCol  = ColW'(SCREEN_WIDTH - 1);
  localparam logic [ErrW-1:0] WidthE   = ErrW'(SCREEN_WIDTH);
  localparam logic [ErrW-1:0] StepRE   = ErrW'(StepR);
  localparam fix_t            CamInit  = fix_t'(-(32'sd1 <<< FRAC_BITS));
  localparam fix_t            CamStepQ = fix_t'(StepQ);
  localparam fix_t            CamStepP = fix_t'(StepQ + 1);

  raygen_state_t   state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  fix_t            cam_q, cam_d;
  logic [ErrW-1:0] err_q, err_d;
  logic [ErrW-1:0] err_sum;

  fix_t pos_x_q, pos_y_q, dir_x_q, dir_y_q, plane_x_q, plane_y_q;
  logic latch_pose;

  logic            v1_q, v1_d;
  logic [ColW-1:0] col1_q, col1_d;
  logic            issue;

  logic            valid_q, valid_d;
  logic [ColW-1:0] ocol_q, ocol_d;
  fix_t            dx_q, dx_d, dy_q, dy_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [15:0]     shx, shy;
  logic            stall, adv;

  assign stall = valid_q && !ray_ready_in;
  assign adv   = !stall;

  // Frame sequencer plus the exact cameraX accumulator.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cam_d      = cam_q;
    err_d      = err_q;
    latch_pose = 1'b0;
    issue      = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    err_sum    = err_q + StepRE;

    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          latch_pose = 1'b1;
          col_d      = '0;
          cam_d      = CamInit;
          err_d      = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          issue = 1'b1;
          col_d = col_q + ColW'(1);
          if (err_sum >= WidthE) begin
            err_d = err_sum - WidthE;
            cam_d = cam_q + CamStepP;
          end else begin
            err_d = err_sum;
            cam_d = cam_q + CamStepQ;
          end
          if (col_q == LastCol) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (valid_q && ray_ready_in && last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // S1 tag and S2 output register; both freeze on a stall.
  always_comb begin
    v1_d    = v1_q;
    col1_d  = col1_q;
    valid_d = valid_q;
    ocol_d  = ocol_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    last_d  = last_q;
    if (adv) begin
      v1_d    = issue;
      col1_d  = col_q;
      valid_d = v1_q;
      ocol_d  = col1_q;
      dx_d    = dir_x_q + fix_t'(shx);
      dy_d    = dir_y_q + fix_t'(shy);
      last_d  = v1_q && (col1_q == LastCol);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      col_q     <= '0;
      cam_q     <= '0;
      err_q     <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      dir_x_q   <= '0;
      dir_y_q   <= '0;
      plane_x_q <= '0;
      plane_y_q <= '0;
      v1_q      <= 1'b0;
      col1_q    <= '0;
      valid_q   <= 1'b0;
      ocol_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cam_q   <= cam_d;
      err_q   <= err_d;
      if (latch_pose) begin
        pos_x_q   <= pos_x_in;
        pos_y_q   <= pos_y_in;
        dir_x_q   <= dir_x_in;
        dir_y_q   <= dir_y_in;
        plane_x_q <= plane_x_in;
        plane_y_q <= plane_y_in;
      end
      v1_q    <= v1_d;
      col1_q  <= col1_d;
      valid_q <= valid_d;
      ocol_q  <= ocol_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  fix_mul_shift u_mul_x (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .en_i   (adv),
    .a_i    (plane_x_q),
    .b_i    (cam_q),
    .res_o  (shx)
  );

  fix_mul_shift u_mul_y (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .en_i   (adv),
    .a_i    (plane_y_q),
    .b_i    (cam_q),
    .res_o  (shy)
  );

  assign ray_valid_out  = valid_q;
  assign ray_col_out    = ocol_q;
  assign ray_dir_x_out  = dx_q;
  assign ray_dir_y_out  = dy_q;
  assign step_x_neg_out = dx_q[15];
  assign step_y_neg_out = dy_q[15];
  assign ray_last_out   = last_q;
  assign map_x_out      = pos_x_q[15:8];
  assign map_y_out      = pos_y_q[15:8];
  assign pose_x_out     = pos_x_q;
  assign pose_y_out     = pos_y_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_ray_column_gen.sv
// Self-checking bench: a 320-column and a 3-column instance share the pose
// inputs; sel routes start/ready to one of them and muxes its outputs.
module tb_ray_column_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ready, sel;
  logic [15:0] pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;

  logic        a_valid, a_snx, a_sny, a_last, a_busy, a_done;
  logic [8:0]  a_col;
  logic [15:0] a_dx, a_dy, a_px, a_py;
  logic [7:0]  a_mx, a_my;
  logic        b_valid, b_snx, b_sny, b_last, b_busy, b_done;
  logic [1:0]  b_col;
  logic [15:0] b_dx, b_dy, b_px, b_py;
  logic [7:0]  b_mx, b_my;

  logic        o_valid, o_snx, o_sny, o_last, o_busy, o_done;
  logic [8:0]  o_col;
  logic [15:0] o_dx, o_dy, o_px, o_py;
  logic [7:0]  o_mx, o_my;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ray_column_gen #(.SCREEN_WIDTH(320)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start & ~sel),
    .pos_x_in(pos_x), .pos_y_in(pos_y), .dir_x_in(dir_x), .dir_y_in(dir_y),
    .plane_x_in(plane_x), .plane_y_in(plane_y), .ray_ready_in(ready & ~sel),
    .ray_valid_out(a_valid), .ray_col_out(a_col), .ray_dir_x_out(a_dx),
    .ray_dir_y_out(a_dy), .map_x_out(a_mx), .map_y_out(a_my),
    .step_x_neg_out(a_snx), .step_y_neg_out(a_sny), .ray_last_out(a_last),
    .pose_x_out(a_px), .pose_y_out(a_py), .busy_out(a_busy), .frame_done_out(a_done)
  );

  ray_column_gen #(.SCREEN_WIDTH(3)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start & sel),
    .pos_x_in(pos_x), .pos_y_in(pos_y), .dir_x_in(dir_x), .dir_y_in(dir_y),
    .plane_x_in(plane_x), .plane_y_in(plane_y), .ray_ready_in(ready & sel),
    .ray_valid_out(b_valid), .ray_col_out(b_col), .ray_dir_x_out(b_dx),
    .ray_dir_y_out(b_dy), .map_x_out(b_mx), .map_y_out(b_my),
    .step_x_neg_out(b_snx), .step_y_neg_out(b_sny), .ray_last_out(b_last),
    .pose_x_out(b_px), .pose_y_out(b_py), .busy_out(b_busy), .frame_done_out(b_done)
  );

  assign o_valid = sel ? b_valid : a_valid;
  assign o_col   = sel ? {7'd0, b_col} : a_col;
  assign o_dx    = sel ? b_dx : a_dx;
  assign o_dy    = sel ? b_dy : a_dy;
  assign o_mx    = sel ? b_mx : a_mx;
  assign o_my    = sel ? b_my : a_my;
  assign o_snx   = sel ? b_snx : a_snx;
  assign o_sny   = sel ? b_sny : a_sny;
  assign o_last  = sel ? b_last : a_last;
  assign o_px    = sel ? b_px : a_px;
  assign o_py    = sel ? b_py : a_py;
  assign o_busy  = sel ? b_busy : a_busy;
  assign o_done  = sel ? b_done : a_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {23'd0, o_valid, o_last, o_snx, o_sny, o_busy, o_done}, 32'd0);
    chk({tag, "_col"}, {23'd0, o_col}, 32'd0);
    chk({tag, "_dir"}, {o_dx, o_dy}, 32'd0);
    chk({tag, "_pose"}, {o_px, o_py}, 32'd0);
    chk({tag, "_map"}, {16'd0, o_mx, o_my}, 32'd0);
  endtask

  // Reference: cam(x) = floor(512x/W) - 256, ray = dir + (plane*cam)>>>8 (16-bit wrap).
  function automatic logic [15:0] ray_ref(input logic [15:0] d, input logic [15:0] pl,
                                          input int x, input int w);
    int cam;
    int p;
    cam = (512 * x) / w - 256;
    p   = int'($signed(pl)) * cam;
    return d + 16'(p >>> 8);
  endfunction

  task automatic run_frame(input int w, input int pct, input int abort_col,
                           input bit tricks, input int spot);
    int exp_col = 0;
    int dones = 0;
    int cyc = 0;
    bit prev_stall = 0;
    bit prev_last = 0;
    bit poked = 0;
    logic [15:0] lpx, lpy, ldx, ldy, lplx, lply, ex, ey, s_dx, s_dy;
    logic [8:0]  s_col;
    logic        s_last;
    s_dx = '0; s_dy = '0; s_col = '0; s_last = 1'b0;

    @(negedge clk);
    start = 1'b1;
    lpx = pos_x; lpy = pos_y; ldx = dir_x; ldy = dir_y; lplx = plane_x; lply = plane_y;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", o_busy, 1);

    while (cyc < 4000) begin
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_col", o_col, s_col);
        chk("stall_dir", {o_dx, o_dy}, {s_dx, s_dy});
        chk("stall_last", o_last, s_last);
      end
      if (o_done) begin
        chk("done_after_last", prev_last, 1);
        chk("busy_at_done", o_busy, 1);
        chk("valid_at_done", o_valid, 0);
        dones++;
        break;
      end
      if (abort_col >= 0 && o_valid && int'(o_col) == abort_col) begin
        ready = 1'b0;
        @(posedge clk);
        #2;
        chk("abort_stalled_valid", o_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ready = ($urandom_range(0, 99) < pct);
      if (tricks && exp_col == 50 && !poked) begin
        poked = 1;
        pos_x = pos_x ^ 16'h5A5A;
        pos_y = ~pos_y;
        start = 1'b1;
      end
      prev_last = 0;
      if (o_valid && ready) begin
        ex = ray_ref(ldx, lplx, exp_col, w);
        ey = ray_ref(ldy, lply, exp_col, w);
        chk("col", o_col, exp_col);
        chk("dir_x", o_dx, ex);
        chk("dir_y", o_dy, ey);
        chk("map", {o_mx, o_my}, {lpx[15:8], lpy[15:8]});
        chk("step_neg", {o_snx, o_sny}, {ex[15], ey[15]});
        chk("last", o_last, (exp_col == w - 1));
        chk("pose", {o_px, o_py}, {lpx, lpy});
        if (spot == 1 && exp_col == 0)   chk("spot_c0_dy", o_dy, 16'hFF58);
        if (spot == 1 && exp_col == 160) chk("spot_c160_dy", o_dy, 16'h0000);
        if (spot == 1 && exp_col == 319) chk("spot_c319_dy", o_dy, 16'h00A6);
        if (spot == 1) chk("spot_dx", {o_dx, 15'd0, o_snx}, {16'hFF00, 16'd1});
        if (spot == 2 && exp_col == 0) chk("w3_cam0", o_dx, 16'hFF00);
        if (spot == 2 && exp_col == 1) chk("w3_cam1", o_dx, 16'hFFAA);
        if (spot == 2 && exp_col == 2) chk("w3_cam2", o_dx, 16'h0055);
        prev_last = (exp_col == w - 1);
        exp_col++;
      end
      prev_stall = o_valid && !ready;
      s_col = o_col; s_dx = o_dx; s_dy = o_dy; s_last = o_last;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end

    chk("frame_columns", exp_col, w);
    chk("done_pulses", dones, 1);
    @(negedge clk);
    chk("busy_cleared", o_busy, 0);
    chk("done_single", o_done, 0);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0;
    pos_x = '0; pos_y = '0; dir_x = '0; dir_y = '0; plane_x = '0; plane_y = '0;
    #3 rst_n = 1'b0;
    #9 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reference pose, ready held high.
    pos_x = 16'h0A80; pos_y = 16'h0340; dir_x = 16'hFF00; dir_y = 16'h0000;
    plane_x = 16'h0000; plane_y = 16'h00A8;
    run_frame(320, 100, -1, 0, 1);

    // Random ready around 50%.
    run_frame(320, 50, -1, 0, 1);

    // Pose inputs change and start re-pulsed mid-frame.
    run_frame(320, 70, -1, 1, 0);

    // Reset while stalled at column 100, then a clean frame.
    pos_x = 16'h0A80; pos_y = 16'h0340;
    run_frame(320, 100, 100, 0, 0);
    run_frame(320, 60, -1, 0, 1);

    // Random poses.
    for (int i = 0; i < 3; i++) begin
      pos_x = 16'($urandom); pos_y = 16'($urandom);
      dir_x = 16'($urandom); dir_y = 16'($urandom);
      plane_x = 16'($urandom); plane_y = 16'($urandom);
      run_frame(320, 50, -1, 0, 0);
    end

    // Three-column instance.
    sel = 1'b1;
    pos_x = 16'h1234; pos_y = 16'h5678; dir_x = '0; dir_y = '0;
    plane_x = 16'h0100; plane_y = 16'h0100;
    run_frame(3, 100, -1, 0, 2);
    pos_x = 16'($urandom); pos_y = 16'($urandom);
    dir_x = 16'($urandom); dir_y = 16'($urandom);
    plane_x = 16'($urandom); plane_y = 16'($urandom);
    run_frame(3, 50, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
